hex_byte_printer: RTL

- Sits between the SPI byte master's read-data path and the UART TX FIFO.
- Converts each raw received byte into two ASCII hex characters, followed by a separator or a line break.
- Output drives the UART FIFO's wr_en/wr_data/ready interface directly.
- Lets flash ID and status dumps appear on the serial terminal as readable text, e.g. "EF 40 18\r\n".

---
 rtl/hex_print_pkg.sv | 25 ++
 rtl/nibble_to_ascii.sv | 19 +
 rtl/hex_byte_printer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hex_print_pkg.sv
// rtl/hex_print_pkg.sv - shared ASCII constants and FSM state encoding for hex_byte_printer (HEX_BYTE_PRINTER_PREFIX_EN adds PFX states)
package hex_print_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_X    = 8'h78;
    localparam logic [7:0] ASCII_A_UP = 8'h41;
    localparam logic [7:0] ASCII_A_LO = 8'h61;

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef HEX_BYTE_PRINTER_PREFIX_EN
        ST_PFX0,
        ST_PFX1,
`endif
        ST_HI,
        ST_LO,
        ST_SEP,
        ST_CR,
        ST_LF
    } state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// rtl/nibble_to_ascii.sv - combinational 4-bit value to ASCII hex digit
module nibble_to_ascii
    import hex_print_pkg::*;
#(
    parameter int UPPERCASE = 1
) (
    input  logic [3:0] nib,
    output logic [7:0] ch
);

    always_comb begin
        if (nib < 4'd10) begin
            ch = ASCII_0 + {4'd0, nib};
        end else begin
            ch = ((UPPERCASE != 0) ? ASCII_A_UP : ASCII_A_LO) + {4'd0, nib} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_byte_printer.sv
// rtl/hex_byte_printer.sv - prints raw bytes as ASCII hex text into a UART FIFO
// Optional "0x" prefix per byte when HEX_BYTE_PRINTER_PREFIX_EN is defined.
module hex_byte_printer
    import hex_print_pkg::*;
#(
    parameter int         UPPERCASE  = 1,
    parameter logic [7:0] SEP_CHAR   = 8'h20,
    parameter int         LINE_BYTES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       ready,
    output logic       wr_en,
    output logic [7:0] wr_data
);

    localparam int CNT_RAW = $clog2(LINE_BYTES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       held;
    logic             held_last;
    logic [CNT_W-1:0] line_cnt;
    logic             accept;
    logic             emit;
    logic             line_end;
    logic [3:0]       nib;
    logic [7:0]       nib_ch;
    logic [7:0]       ch;

    assign in_ready = rst_n && (state == ST_IDLE);
    assign accept   = in_valid && in_ready;

    // line_cnt has not yet counted the byte whose LO is going out
    assign line_end = held_last ||
                      ((LINE_BYTES != 0) && ((int'(line_cnt) + 1) == LINE_BYTES));

    assign nib = (state == ST_HI) ? held[7:4] : held[3:0];

    nibble_to_ascii #(
        .UPPERCASE(UPPERCASE)
    ) u_nib (
        .nib(nib),
        .ch (nib_ch)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef HEX_BYTE_PRINTER_PREFIX_EN
                    state_nxt = ST_PFX0;
`else
                    state_nxt = ST_HI;
`endif
                end
            end
`ifdef HEX_BYTE_PRINTER_PREFIX_EN
            ST_PFX0: if (ready) state_nxt = ST_PFX1;
            ST_PFX1: if (ready) state_nxt = ST_HI;
`endif
            ST_HI:   if (ready) state_nxt = ST_LO;
            ST_LO:   if (ready) state_nxt = line_end ? ST_CR : ST_SEP;
            ST_SEP:  if (ready) state_nxt = ST_IDLE;
            ST_CR:   if (ready) state_nxt = ST_LF;
            ST_LF:   if (ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        emit = (state != ST_IDLE) && ready;
        ch   = 8'h00;
        case (state)
`ifdef HEX_BYTE_PRINTER_PREFIX_EN
            ST_PFX0: ch = ASCII_0;
            ST_PFX1: ch = ASCII_X;
`endif
            ST_HI:   ch = nib_ch;
            ST_LO:   ch = nib_ch;
            ST_SEP:  ch = SEP_CHAR;
            ST_CR:   ch = ASCII_CR;
            ST_LF:   ch = ASCII_LF;
            default: ch = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held      <= 8'h00;
            held_last <= 1'b0;
            line_cnt  <= '0;
            wr_en     <= 1'b0;
            wr_data   <= 8'h00;
        end else begin
            wr_en <= emit;
            if (emit) begin
                wr_data <= ch;
            end
            if (accept) begin
                held      <= in_data;
                held_last <= in_last;
            end
            // saturating count; a LINE_BYTES of 0 keeps it parked at zero
            if (emit && (state == ST_LF)) begin
                line_cnt <= '0;
            end else if (emit && (state == ST_LO) && (int'(line_cnt) < LINE_BYTES)) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

endmodule
